// File: rtl/burst_fifo.sv
// Parametrised single-clock FIFO with valid/ready read side and a run-time
// selectable burst mode (fill completely, then drain completely).
module burst_fifo #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 8,
   parameter int AFULL_LVL = DEPTH - 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     burst_mode,
   input  logic [WIDTH-1:0]         data_1,
   input  logic                     data_1_en,
   output logic                     data_1_ready,
   output logic [WIDTH-1:0]         data_2,
   output logic                     data_2_valid,
   input  logic                     data_2_ready,
   output logic                     buffer_empty,
   output logic                     buffer_full,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   buffer_count,
   output logic                     overflow
);

   localparam int          AW      = $clog2(DEPTH);
   localparam int unsigned CW      = AW + 1;
   localparam logic [AW:0] DEPTH_C = CW'(DEPTH);
   localparam logic [AW:0] AFULL_C = CW'(AFULL_LVL);

   typedef enum logic {FILL, DRAIN} state_e;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             overflow_q, overflow_d;
   state_e           state_q, state_d;

   logic full, empty, wr_ready, rd_valid, push, pop;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);

   // Handshake qualifiers depend only on registered state and the mode input.
   always_comb begin
      wr_ready = !full;
      rd_valid = !empty;
      if (burst_mode) begin
         if (state_q == DRAIN) wr_ready = 1'b0;
         else                  rd_valid = 1'b0;
      end
   end

   assign push = data_1_en && wr_ready;
   assign pop  = rd_valid && data_2_ready;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      state_d    = state_q;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         state_d    = FILL;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         overflow_d = overflow_q | (data_1_en & !wr_ready);
         // Comparing against count_d also releases a FIFO that was already full
         // when the mode switched from stream to burst.
         if (!burst_mode)                                state_d = FILL;
         else if (state_q == FILL  && count_d == DEPTH_C) state_d = DRAIN;
         else if (state_q == DRAIN && count_d == '0)      state_d = FILL;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= FILL;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= data_1;
   end

   assign data_1_ready = wr_ready;
   assign data_2_valid = rd_valid;
   assign data_2       = rd_valid ? mem_q[rd_ptr_q] : '0;
   assign buffer_empty = empty;
   assign buffer_full  = full;
   assign almost_full  = (count_q >= AFULL_C);
   assign buffer_count = count_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_burst_fifo.sv
// Randomized and directed bench for burst_fifo, checked against a queue-based
// model of the FIFO's externally visible behaviour.
module tb_burst_fifo;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int AFULL = DEPTH - 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             burst_mode;
   logic [WIDTH-1:0] data_1;
   logic             data_1_en;
   logic             data_1_ready;
   logic [WIDTH-1:0] data_2;
   logic             data_2_valid;
   logic             data_2_ready;
   logic             buffer_empty;
   logic             buffer_full;
   logic             almost_full;
   logic [AW:0]      buffer_count;
   logic             overflow;

   always #5 clk = ~clk;

   burst_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
      .clk(clk), .rst(rst), .flush(flush), .burst_mode(burst_mode),
      .data_1(data_1), .data_1_en(data_1_en), .data_1_ready(data_1_ready),
      .data_2(data_2), .data_2_valid(data_2_valid), .data_2_ready(data_2_ready),
      .buffer_empty(buffer_empty), .buffer_full(buffer_full),
      .almost_full(almost_full), .buffer_count(buffer_count),
      .overflow(overflow)
   );

   int checks = 0;
   int errors = 0;

   // Model: stored words in order, whether a burst drain is in progress, sticky overflow.
   logic [WIDTH-1:0] q[$];
   bit               drain_m;
   bit               ovf_m;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit exp_ready();
      return (q.size() != DEPTH) && !(burst_mode && drain_m);
   endfunction

   function automatic bit exp_valid();
      return (q.size() != 0) && (!burst_mode || drain_m);
   endfunction

   task automatic model_reset();
      q.delete();
      drain_m = 1'b0;
      ovf_m   = 1'b0;
   endtask

   task automatic check_outputs();
      logic [WIDTH-1:0] head;
      head = exp_valid() ? q[0] : '0;
      check("data_1_ready", 64'(data_1_ready), 64'(exp_ready()));
      check("data_2_valid", 64'(data_2_valid), 64'(exp_valid()));
      check("data_2",       64'(data_2),       64'(head));
      check("buffer_count", 64'(buffer_count), 64'(q.size()));
      check("buffer_empty", 64'(buffer_empty), 64'(q.size() == 0));
      check("buffer_full",  64'(buffer_full),  64'(q.size() == DEPTH));
      check("almost_full",  64'(almost_full),  64'(q.size() >= AFULL));
      check("overflow",     64'(overflow),     64'(ovf_m));
   endtask

   // Apply inputs just after an edge, check mid-cycle, advance the model at the edge.
   task automatic step(input bit en, input logic [WIDTH-1:0] d, input bit rdy,
                       input bit fl, input bit mode);
      bit r, v;
      data_1_en    = en;
      data_1       = d;
      data_2_ready = rdy;
      flush        = fl;
      burst_mode   = mode;
      #4;
      check_outputs();
      r = exp_ready();
      v = exp_valid();
      @(posedge clk);
      if (fl) begin
         model_reset();
      end else begin
         if (en && !r) ovf_m = 1'b1;
         if (v && rdy) void'(q.pop_front());
         if (en && r)  q.push_back(d);
         if (!mode)                              drain_m = 1'b0;
         else if (!drain_m && q.size() == DEPTH) drain_m = 1'b1;
         else if (drain_m && q.size() == 0)      drain_m = 1'b0;
      end
      #1;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; burst_mode = 1'b0;
      data_1 = '0; data_1_en = 1'b0; data_2_ready = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(posedge clk); #1;
      rst = 1'b1;

      // Stream, consumer always ready: word passes straight through.
      for (int i = 1; i <= 8; i++) step(1'b1, WIDTH'(i), 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Stream, consumer stalled: fill, reject 9th, then two drain/refill passes.
      for (int i = 1; i <= 9; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++)  step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++)  step(1'b1, WIDTH'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++)  step(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Burst: fill 8, drain 8 with a write attempt mid-drain.
      step(1'b0, '0, 1'b1, 1'b1, 1'b1);
      for (int i = 1; i <= 8; i++) step(1'b1, WIDTH'(16'h0200 + i), 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++)  step(i == 3, 16'hdead, 1'b1, 1'b0, 1'b1);
      step(1'b1, 16'h0301, 1'b0, 1'b0, 1'b1);

      // Burst with 5 stored, then switch to stream to release them.
      for (int i = 2; i <= 5; i++) step(1'b1, WIDTH'(16'h0300 + i), 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++)  step(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Flush with count=5, overflow set, push and pop requested together.
      for (int i = 0; i < 9; i++) step(1'b1, WIDTH'(16'h0400 + i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 16'h0499, 1'b1, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Async reset between edges while a burst drain is in progress.
      for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(16'h0500 + i), 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b1, 1'b0, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk); #1;
      rst = 1'b1;
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);

      // Random traffic with occasional mode changes and flushes.
      begin
         bit mode = 1'b0;
         int rdy_bias = 50;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(63) == 0)  mode = ~mode;
            if ($urandom_range(99) == 0)  rdy_bias = int'($urandom_range(90, 10));
            step($urandom_range(99) < 60, WIDTH'($urandom),
                 $urandom_range(99) < rdy_bias, $urandom_range(199) == 0, mode);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
